// File: rtl/board_cell_painter.sv
// Rasterises one Tetris board cell (or the whole board on clear) into the VGA index RAM,
// one pixel per clock in raster order, behind a valid/ready command handshake.
module board_cell_painter #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned ORIGIN_X   = 240,
    parameter int unsigned ORIGIN_Y   = 80,
    parameter int unsigned CELL_W     = 16,
    parameter int unsigned CELL_H     = 16,
    parameter int unsigned BOARD_COLS = 10,
    parameter int unsigned BOARD_ROWS = 20,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned IDX_W      = 8
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              iCMD_VALID,
    output logic              oCMD_READY,
    input  logic              iCMD_CLEAR,
    input  logic [4:0]        iCMD_ROW,
    input  logic [3:0]        iCMD_COL,
    input  logic [IDX_W-1:0]  iCMD_INDEX,
    input  logic              iCMD_BORDER_EN,
    input  logic [IDX_W-1:0]  iCMD_BORDER_INDEX,
    output logic              oWR_EN,
    output logic [ADDR_W-1:0] oWR_ADDR,
    output logic [IDX_W-1:0]  oWR_DATA,
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oERR
);

    localparam int unsigned BOARD_W = BOARD_COLS * CELL_W;
    localparam int unsigned BOARD_H = BOARD_ROWS * CELL_H;
    localparam int unsigned CNT_W   = $clog2((BOARD_W > BOARD_H) ? BOARD_W : BOARD_H);

    typedef enum logic [1:0] {StIdle, StPaint, StDone} state_e;

    state_e             state_q, state_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [IDX_W-1:0]   wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic [CNT_W-1:0]   px_q, px_d, py_q, py_d;
    logic [CNT_W-1:0]   w_last_q, w_last_d, h_last_q, h_last_d;
    logic [IDX_W-1:0]   fill_q, fill_d, bidx_q, bidx_d;
    logic               ben_q, ben_d;

    logic [ADDR_W-1:0]  cell_x, cell_y, start_addr, base_nxt;
    logic [CNT_W-1:0]   px_nxt, py_nxt;
    logic               in_range, wrap, last_px, accept, ben_new;

    function automatic logic on_border(input logic [CNT_W-1:0] x, input logic [CNT_W-1:0] y);
        return (x == '0) || (y == '0) || (x == CNT_W'(CELL_W - 1)) || (y == CNT_W'(CELL_H - 1));
    endfunction

    // Start address uses constant multiplies once per command; per-pixel stepping is additive.
    always_comb begin
        cell_x = ADDR_W'(ORIGIN_X);
        cell_y = ADDR_W'(ORIGIN_Y);
        if (!iCMD_CLEAR) begin
            cell_x = cell_x + ADDR_W'(iCMD_COL) * ADDR_W'(CELL_W);
            cell_y = cell_y + ADDR_W'(iCMD_ROW) * ADDR_W'(CELL_H);
        end
        start_addr = cell_y * ADDR_W'(H_RES) + cell_x;
        in_range   = iCMD_CLEAR ||
                     ((iCMD_ROW < 5'(BOARD_ROWS)) && (iCMD_COL < 4'(BOARD_COLS)));
        accept     = iCMD_VALID && ready_q && (state_q == StIdle);
        ben_new    = iCMD_BORDER_EN && !iCMD_CLEAR;
    end

    always_comb begin
        wrap     = (px_q == w_last_q);
        last_px  = wrap && (py_q == h_last_q);
        px_nxt   = wrap ? '0 : px_q + 1'b1;
        py_nxt   = wrap ? py_q + 1'b1 : py_q;
        base_nxt = wrap ? row_base_q + ADDR_W'(H_RES) : row_base_q;
    end

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        row_base_d = row_base_q;
        px_d       = px_q;
        py_d       = py_q;
        w_last_d   = w_last_q;
        h_last_d   = h_last_q;
        fill_d     = fill_q;
        bidx_d     = bidx_q;
        ben_d      = ben_q;

        unique case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                if (accept) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = StPaint;
                        ready_d    = 1'b0;
                        busy_d     = 1'b1;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = start_addr;
                        row_base_d = start_addr;
                        px_d       = '0;
                        py_d       = '0;
                        w_last_d   = iCMD_CLEAR ? CNT_W'(BOARD_W - 1) : CNT_W'(CELL_W - 1);
                        h_last_d   = iCMD_CLEAR ? CNT_W'(BOARD_H - 1) : CNT_W'(CELL_H - 1);
                        fill_d     = iCMD_INDEX;
                        bidx_d     = iCMD_BORDER_INDEX;
                        ben_d      = ben_new;
                        // Pixel (0,0) is always on the border.
                        wr_data_d  = ben_new ? iCMD_BORDER_INDEX : iCMD_INDEX;
                    end
                end
            end
            StPaint: begin
                if (last_px) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    wr_en_d    = 1'b1;
                    px_d       = px_nxt;
                    py_d       = py_nxt;
                    row_base_d = base_nxt;
                    wr_addr_d  = base_nxt + ADDR_W'(px_nxt);
                    wr_data_d  = (ben_q && on_border(px_nxt, py_nxt)) ? bidx_q : fill_q;
                end
            end
            StDone: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            row_base_q <= '0;
            px_q       <= '0;
            py_q       <= '0;
            w_last_q   <= '0;
            h_last_q   <= '0;
            fill_q     <= '0;
            bidx_q     <= '0;
            ben_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            row_base_q <= row_base_d;
            px_q       <= px_d;
            py_q       <= py_d;
            w_last_q   <= w_last_d;
            h_last_q   <= h_last_d;
            fill_q     <= fill_d;
            bidx_q     <= bidx_d;
            ben_q      <= ben_d;
        end
    end

    assign oCMD_READY = ready_q;
    assign oBUSY      = busy_q;
    assign oDONE      = done_q;
    assign oERR       = err_q;
    assign oWR_EN     = wr_en_q;
    assign oWR_ADDR   = wr_addr_q;
    assign oWR_DATA   = wr_data_q;

endmodule

// File: tb/tb_board_cell_painter.sv
// Bench for board_cell_painter: per-cycle comparison against a rectangle-level model of the
// expected write stream, plus literal expectations for the directed commands.
module tb_board_cell_painter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_clear = 1'b0;
    logic [4:0]  cmd_row = '0;
    logic [3:0]  cmd_col = '0;
    logic [7:0]  cmd_index = '0;
    logic        cmd_ben = 1'b0;
    logic [7:0]  cmd_bidx = '0;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy, done, err;

    board_cell_painter dut (
        .iVGA_CLK         (clk),
        .iRST_n           (rst_n),
        .iCMD_VALID       (cmd_valid),
        .oCMD_READY       (cmd_ready),
        .iCMD_CLEAR       (cmd_clear),
        .iCMD_ROW         (cmd_row),
        .iCMD_COL         (cmd_col),
        .iCMD_INDEX       (cmd_index),
        .iCMD_BORDER_EN   (cmd_ben),
        .iCMD_BORDER_INDEX(cmd_bidx),
        .oWR_EN           (wr_en),
        .oWR_ADDR         (wr_addr),
        .oWR_DATA         (wr_data),
        .oBUSY            (busy),
        .oDONE            (done),
        .oERR             (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int prints = 0;

    typedef struct {
        bit          we;
        logic [18:0] addr;
        logic [7:0]  data;
        bit          done;
        bit          err;
        bit          ready;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    exp_t nxt;

    // Model statistics of the most recently accepted command.
    int          m_cnt, m_bcnt;
    logic [18:0] m_first, m_last;

    // Statistics of what the DUT actually wrote since the last clear_stats.
    int          d_cnt, d_bcnt, d_done, d_err, d_xmin, d_xmax, d_rowlen;
    logic [18:0] d_first, d_last, d_row1;
    logic [7:0]  d_bsel;

    task automatic fail(input string name, input longint act, input longint exp);
        errors++;
        if (prints < 40) begin
            prints++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pin(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) fail(name, act, exp);
    endtask

    // Expected write stream straight from the geometry: rectangle origin, size, border rule.
    task automatic model_accept();
        exp_t e;
        int x0, y0, w, h, a;
        bit bord;
        m_cnt  = 0;
        m_bcnt = 0;
        e.done = 0; e.err = 0; e.ready = 0; e.we = 0; e.addr = '0; e.data = '0;
        if (!cmd_clear && (cmd_row > 19 || cmd_col > 9)) begin
            e.err   = 1;
            e.ready = 1;
            q.push_back(e);
            return;
        end
        if (cmd_clear) begin
            x0 = 240; y0 = 80; w = 160; h = 320;
        end else begin
            x0 = 240 + int'(cmd_col) * 16; y0 = 80 + int'(cmd_row) * 16; w = 16; h = 16;
        end
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                a    = (y0 + y) * 640 + x0 + x;
                bord = !cmd_clear && cmd_ben && (x == 0 || y == 0 || x == w - 1 || y == h - 1);
                e.we   = 1;
                e.addr = 19'(a);
                e.data = bord ? cmd_bidx : cmd_index;
                q.push_back(e);
                if (m_cnt == 0) m_first = e.addr;
                m_last = e.addr;
                m_cnt++;
                if (bord) m_bcnt++;
            end
        end
        e.we   = 0;
        e.done = 1;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if ({wr_en, busy, done, err, cmd_ready} != 5'b0) fail("reset_ctrl", {wr_en, busy, done, err, cmd_ready}, 0);
            if (wr_addr != 0) fail("reset_addr", wr_addr, 0);
            if (wr_data != 0) fail("reset_data", wr_data, 0);
            q.delete();
            cur.we = 0; cur.addr = '0; cur.data = '0; cur.done = 0; cur.err = 0; cur.ready = 0;
        end else begin
            checks++;
            if (wr_en !== cur.we)       fail("wr_en", wr_en, cur.we);
            if (wr_addr !== cur.addr)   fail("wr_addr", wr_addr, cur.addr);
            if (wr_data !== cur.data)   fail("wr_data", wr_data, cur.data);
            if (busy !== cur.we)        fail("busy", busy, cur.we);
            if (done !== cur.done)      fail("done", done, cur.done);
            if (err !== cur.err)        fail("err", err, cur.err);
            if (cmd_ready !== cur.ready) fail("ready", cmd_ready, cur.ready);
            if (wr_en) begin
                if (d_cnt == 0) d_first = wr_addr;
                if (d_cnt == d_rowlen) d_row1 = wr_addr;
                d_last = wr_addr;
                d_cnt++;
                if (wr_data == d_bsel) d_bcnt++;
                if (int'(wr_addr) % 640 < d_xmin) d_xmin = int'(wr_addr) % 640;
                if (int'(wr_addr) % 640 > d_xmax) d_xmax = int'(wr_addr) % 640;
            end
            if (done) d_done++;
            if (err) d_err++;
            if (cmd_valid && cur.ready) model_accept();
            if (q.size() > 0) begin
                nxt = q.pop_front();
                if (!nxt.we) begin
                    nxt.addr = cur.addr;
                    nxt.data = cur.data;
                end
                cur = nxt;
            end else begin
                cur.we = 0; cur.done = 0; cur.err = 0; cur.ready = 1;
            end
        end
    end

    task automatic clear_stats(input logic [7:0] bsel, input int rowlen);
        @(posedge clk); #1;
        d_cnt = 0; d_bcnt = 0; d_done = 0; d_err = 0; d_xmin = 640; d_xmax = -1;
        d_first = '0; d_last = '0; d_row1 = '0; d_bsel = bsel; d_rowlen = rowlen;
    endtask

    task automatic send(input bit c, input logic [4:0] r, input logic [3:0] co,
                        input logic [7:0] idx, input bit be, input logic [7:0] bi);
        int n;
        @(posedge clk); #1;
        cmd_clear = c; cmd_row = r; cmd_col = co; cmd_index = idx; cmd_ben = be; cmd_bidx = bi;
        cmd_valid = 1;
        n = 0;
        @(negedge clk); #1;
        while (!cmd_ready && n < 60000) begin
            n++;
            @(negedge clk); #1;
        end
        if (!cmd_ready) fail("accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 0;
        // Fields must be ignored after acceptance.
        cmd_clear = 1'($urandom); cmd_row = 5'($urandom); cmd_col = 4'($urandom);
        cmd_index = 8'($urandom); cmd_ben = 1'($urandom); cmd_bidx = 8'($urandom);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!cmd_ready && n < 60000);
        if (!cmd_ready) fail("ready_timeout", 0, 1);
    endtask

    initial begin
        clear_stats(8'h00, 16);
        repeat (2) @(negedge clk);
        #1;
        pin("reset_ready", cmd_ready, 0);
        @(posedge clk); #1;
        rst_n = 1;

        clear_stats(8'h00, 16);
        repeat (100) @(posedge clk);
        @(negedge clk); #1;
        pin("idle_writes", d_cnt, 0);
        pin("idle_ready", cmd_ready, 1);

        // Cell (0,0), no border.
        clear_stats(8'h05, 16);
        send(0, 5'd0, 4'd0, 8'h05, 0, 8'h00);
        @(negedge clk); #1;
        pin("first_latency", wr_en, 1);
        wait_ready();
        pin("c00_count", d_cnt, 256);
        pin("c00_first", d_first, 51440);
        pin("c00_last", d_last, 61055);
        pin("c00_fill", d_bcnt, 256);
        pin("c00_done", d_done, 1);
        pin("c00_model_first", m_first, 51440);
        pin("c00_model_last", m_last, 61055);

        // Cell (19,9) with border.
        clear_stats(8'h07, 16);
        send(0, 5'd19, 4'd9, 8'h02, 1, 8'h07);
        wait_ready();
        pin("c199_count", d_cnt, 256);
        pin("c199_first", d_first, 246144);
        pin("c199_last", d_last, 255759);
        pin("c199_border", d_bcnt, 60);
        pin("c199_stride", d_row1 - d_first, 640);
        pin("c199_model_border", m_bcnt, 60);
        pin("c199_model_count", m_cnt, 256);

        // Clear; border request must be ignored.
        clear_stats(8'h00, 160);
        send(1, 5'd5, 4'd3, 8'h00, 1, 8'hff);
        wait_ready();
        pin("clr_count", d_cnt, 51200);
        pin("clr_first", d_first, 51440);
        pin("clr_last", d_last, 255759);
        pin("clr_row1", d_row1, 52080);
        pin("clr_xmin", d_xmin, 240);
        pin("clr_xmax", d_xmax, 399);
        pin("clr_fill", d_bcnt, 51200);
        pin("clr_done", d_done, 1);

        // Out-of-range commands.
        clear_stats(8'h00, 16);
        send(0, 5'd20, 4'd0, 8'h11, 0, 8'h00);
        @(negedge clk); #1;
        pin("err_pulse_row", err, 1);
        pin("err_ready_row", cmd_ready, 1);
        send(0, 5'd0, 4'd10, 8'h11, 0, 8'h00);
        @(negedge clk); #1;
        pin("err_pulse_col", err, 1);
        pin("err_writes", d_cnt, 0);
        pin("err_count", d_err, 2);
        send(0, 5'd3, 4'd4, 8'h22, 0, 8'h00);
        wait_ready();
        pin("post_err_count", d_cnt, 256);
        pin("post_err_first", d_first, (80 + 48) * 640 + 240 + 64);

        // Reset during a paint.
        clear_stats(8'h00, 16);
        send(0, 5'd10, 4'd5, 8'h09, 1, 8'h03);
        begin
            int n;
            n = 0;
            while (d_cnt < 100 && n < 1000) begin
                n++;
                @(negedge clk); #1;
            end
        end
        @(posedge clk); #1;
        rst_n = 0;
        @(negedge clk); #1;
        pin("midrst_wr_en", wr_en, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (3) @(negedge clk);
        #1;
        pin("midrst_writes", d_cnt, 100);
        pin("midrst_no_done", d_done, 0);
        clear_stats(8'h00, 16);
        send(0, 5'd1, 4'd2, 8'h04, 0, 8'h00);
        wait_ready();
        pin("postrst_first", d_first, 61712);
        pin("postrst_count", d_cnt, 256);
        pin("postrst_done", d_done, 1);

        // Randomized commands, some back-to-back while the block is busy.
        for (int k = 0; k < 40; k++) begin
            send(0, 5'($urandom_range(0, 21)), 4'($urandom_range(0, 11)), 8'($urandom),
                 1'($urandom), 8'($urandom));
            if ($urandom_range(0, 2) == 0) wait_ready();
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wait_ready();
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        pin("final_queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
